// File: rtl/coco_mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// 32 radix-2 iterations then one sign-fix/commit cycle; Busy is decoded from state.
module coco_mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] RData1,
  input  logic [WIDTH-1:0] RData2,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] MtData,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state;
  logic [4:0]        cnt;
  logic [1:0]        op_q;
  logic [WIDTH-1:0]  opnd;
  logic [W2-1:0]     acc;
  logic              sign_res;
  logic              sign_dvd;
  logic              div0;
  logic [WIDTH-1:0]  hi_q;
  logic [WIDTH-1:0]  lo_q;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + WIDTH'(1);
  endfunction

  function automatic logic [W2-1:0] neg_2w(input logic [W2-1:0] v);
    return (~v) + W2'(1);
  endfunction

  // Operand sign/magnitude; magnitude of the most negative value is 2^(WIDTH-1) unsigned.
  logic signed [WIDTH-1:0] a_s, b_s;
  logic                    a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]        mag_a, mag_b;

  always_comb begin
    a_s    = signed'(RData1);
    b_s    = signed'(RData2);
    a_neg  = ~Op[0] & (a_s < 0);
    b_neg  = ~Op[0] & (b_s < 0);
    b_zero = (RData2 == '0);
    mag_a  = a_neg ? neg_w(RData1) : RData1;
    mag_b  = b_neg ? neg_w(RData2) : RData2;
  end

  // One iteration: multiply keeps the multiplier in acc low half and shifts the
  // partial product right; divide shifts the dividend out of the low half into
  // the remainder in the high half and shifts quotient bits in.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [W2-1:0]    div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_ok    = acc[W2-1:WIDTH-1] >= {1'b0, opnd};
    div_trial = acc[W2-1:WIDTH-1] - {1'b0, opnd};
    div_next  = div_ok ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                       : {acc[W2-2:0], 1'b0};
  end

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    prod_fix = sign_res ? neg_2w(acc) : acc;
    quo_fix  = div0 ? '1 : (sign_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0]);
    rem_fix  = sign_dvd ? neg_w(acc[W2-1:WIDTH]) : acc[W2-1:WIDTH];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      opnd     <= '0;
      acc      <= '0;
      sign_res <= 1'b0;
      sign_dvd <= 1'b0;
      div0     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (HiWrite) hi_q <= MtData;
          if (LoWrite) lo_q <= MtData;
          if (Start) begin
            state    <= RUN;
            cnt      <= '0;
            op_q     <= Op;
            opnd     <= Op[1] ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (Op[1] ? mag_a : mag_b)};
            sign_res <= (a_neg ^ b_neg) & ~b_zero;
            sign_dvd <= a_neg;
            div0     <= Op[1] & b_zero;
          end
        end
        RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (op_q[1]) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[W2-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_coco_mul_div_unit.sv
// Bench for coco_mul_div_unit: vector table run back-to-back through a
// scoreboard queue, plus hand sequences for reset abort, MT writes and ignored Start.
module tb_coco_mul_div_unit;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] RData1, RData2, MtData;
  logic        HiWrite, LoWrite;
  logic        Busy;
  logic [31:0] Hi, Lo;

  coco_mul_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op),
    .RData1(RData1), .RData2(RData2),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .MtData(MtData),
    .Busy(Busy), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [63:0] sb[$];
  vec_t        vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    Op = op; RData1 = a; RData2 = b; Start = 1'b1;
    sb.push_back({ehi, elo});
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic finish(input int waited, input string name);
    int          cyc;
    logic [63:0] e;
    cyc = waited;
    while (Busy && cyc < 200) begin
      cyc++;
      @(negedge Clk);
    end
    check({name, " busy cycles"}, 64'(cyc), 64'd33);
    if (sb.size() == 0) begin
      check({name, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({name, " Hi"}, 64'(Hi), 64'(e[63:32]));
      check({name, " Lo"}, 64'(Lo), 64'(e[31:0]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"multu_max",   MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_neg3x5", MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{"div_m7_2",    DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"div_ovf",     DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{"divu_by0",    DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    vecs[5]  = '{"div_neg_by0", DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[6]  = '{"mult_7xm2",   MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2};
    vecs[7]  = '{"divu_100_7",  DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{"div_7_m2",    DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[9]  = '{"multu_2p32",  MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[10] = '{"mult_min_sq", MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{"divu_max_16", DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

    Reset = 1'b0; Start = 1'b0; Op = '0; RData1 = '0; RData2 = '0;
    MtData = '0; HiWrite = 1'b0; LoWrite = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset Busy", 64'(Busy), 64'd0);
    check("reset Hi", 64'(Hi), 64'd0);
    check("reset Lo", 64'(Lo), 64'd0);
    Reset = 1'b1;
    @(negedge Clk);

    // Back-to-back: each launch happens in the first idle cycle after the previous op.
    for (int i = 0; i < 12; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
      finish(0, vecs[i].name);
    end

    // Reset pulled mid-run: abort with no commit, now or later.
    launch(MULTU, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38);
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort Busy", 64'(Busy), 64'd0);
    check("abort Hi", 64'(Hi), 64'd0);
    check("abort Lo", 64'(Lo), 64'd0);
    void'(sb.pop_back());
    @(negedge Clk);
    Reset = 1'b1;
    repeat (40) @(negedge Clk);
    check("post-abort Busy", 64'(Busy), 64'd0);
    check("post-abort HiLo", {Hi, Lo}, 64'd0);

    // MT writes in idle.
    HiWrite = 1'b1; MtData = 32'h12345678;
    @(negedge Clk);
    HiWrite = 1'b0;
    check("mthi Hi", 64'(Hi), 64'h12345678);
    check("mthi Lo untouched", 64'(Lo), 64'd0);
    LoWrite = 1'b1; MtData = 32'h55AA55AA;
    @(negedge Clk);
    LoWrite = 1'b0;
    check("mtlo Lo", 64'(Lo), 64'h55AA55AA);

    // MTLO while busy is dropped; Lo moves only at the commit.
    launch(MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C);
    repeat (2) @(negedge Clk);
    LoWrite = 1'b1; MtData = 32'hDEADBEEF;
    @(negedge Clk);
    LoWrite = 1'b0;
    check("busy mtlo Lo", 64'(Lo), 64'h55AA55AA);
    check("busy Hi held", 64'(Hi), 64'h12345678);
    finish(3, "mtlo_busy");

    // Start with MTHI in idle: MT lands at the start edge, then the commit overwrites it.
    HiWrite = 1'b1; MtData = 32'hAAAA5555;
    launch(DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
    HiWrite = 1'b0;
    check("start+mthi Hi", 64'(Hi), 64'hAAAA5555);
    finish(0, "start_mthi");

    // Second Start during the run is ignored.
    launch(MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1);
    repeat (4) @(negedge Clk);
    Op = DIVU; RData1 = 32'h00000064; RData2 = 32'h00000000; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    finish(5, "ignored_start");
    repeat (3) @(negedge Clk);
    check("no restart Busy", 64'(Busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
